// File: rtl/jtag_ir_dr_datapath.sv
// JTAG IR/DR datapath sitting behind the TAP controller.
// Holds IR, BYPASS, IDCODE and USER registers and drives TDO.
module jtag_ir_dr_datapath #(
   parameter int          IR_W       = 4,
   parameter int          USER_W     = 8,
   parameter logic [31:0] IDCODE_VAL = 32'h1234_5001
) (
   input  logic              tck,
   input  logic              trst,
   input  logic [3:0]        state,
   input  logic              tdi,
   input  logic [USER_W-1:0] user_in,
   output logic              tdo,
   output logic              tdo_en,
   output logic [IR_W-1:0]   ir_out,
   output logic [USER_W-1:0] user_out,
   output logic              user_upd
);

   localparam logic [3:0] S_TLR    = 4'd0;
   localparam logic [3:0] S_CAP_DR = 4'd3;
   localparam logic [3:0] S_SH_DR  = 4'd4;
   localparam logic [3:0] S_UPD_DR = 4'd8;
   localparam logic [3:0] S_CAP_IR = 4'd10;
   localparam logic [3:0] S_SH_IR  = 4'd11;
   localparam logic [3:0] S_UPD_IR = 4'd15;

   localparam logic [IR_W-1:0] I_IDCODE = IR_W'(1);
   localparam logic [IR_W-1:0] I_USER   = IR_W'(2);

   logic [IR_W-1:0]   r_ir_sr;
   logic [IR_W-1:0]   r_ir;
   logic [31:0]       r_id_sr;
   logic [USER_W-1:0] r_user_sr;
   logic              r_bp;
   logic [USER_W-1:0] r_user_out;
   logic              r_user_upd;

   logic w_sel_id;
   logic w_sel_user;
   logic w_cap_dr;
   logic w_sh_dr;

   // Instruction decode; anything not IDCODE/USER falls to BYPASS
   assign w_sel_id   = (r_ir == I_IDCODE);
   assign w_sel_user = (r_ir == I_USER);
   assign w_cap_dr   = (state == S_CAP_DR);
   assign w_sh_dr    = (state == S_SH_DR);

   // IR shift stage and the committed instruction
   always_ff @(posedge tck or posedge trst) begin
      if (trst) begin
         r_ir_sr <= IR_W'(1);
         r_ir    <= I_IDCODE;
      end else begin
         case (state)
            S_CAP_IR: r_ir_sr <= IR_W'(1);
            S_SH_IR:  r_ir_sr <= {tdi, r_ir_sr[IR_W-1:1]};
            S_UPD_IR: r_ir    <= r_ir_sr;
            S_TLR:    r_ir    <= I_IDCODE;
            default:  ;
         endcase
      end
   end

   // IDCODE register: capture constant, shift right with tdi at MSB
   always_ff @(posedge tck or posedge trst) begin
      if (trst) begin
         r_id_sr <= IDCODE_VAL;
      end else if (w_sel_id && w_cap_dr) begin
         r_id_sr <= IDCODE_VAL;
      end else if (w_sel_id && w_sh_dr) begin
         r_id_sr <= {tdi, r_id_sr[31:1]};
      end
   end

   // USER shift register: capture user_in, shift right with tdi at MSB
   always_ff @(posedge tck or posedge trst) begin
      if (trst) begin
         r_user_sr <= '0;
      end else if (w_sel_user && w_cap_dr) begin
         r_user_sr <= user_in;
      end else if (w_sel_user && w_sh_dr) begin
         if (USER_W == 1) begin
            r_user_sr <= USER_W'(tdi);
         end else begin
            r_user_sr <= {tdi, r_user_sr[USER_W-1:1]};
         end
      end
   end

   // BYPASS bit: cleared on capture, one-cycle tdi delay while shifting
   always_ff @(posedge tck or posedge trst) begin
      if (trst) begin
         r_bp <= 1'b0;
      end else if (!w_sel_id && !w_sel_user && w_cap_dr) begin
         r_bp <= 1'b0;
      end else if (!w_sel_id && !w_sel_user && w_sh_dr) begin
         r_bp <= tdi;
      end
   end

   // USER parallel output; pulse is high while the new value is first shown
   always_ff @(posedge tck or posedge trst) begin
      if (trst) begin
         r_user_out <= '0;
         r_user_upd <= 1'b0;
      end else begin
         r_user_upd <= 1'b0;
         if (w_sel_user && (state == S_UPD_DR)) begin
            r_user_out <= r_user_sr;
            r_user_upd <= 1'b1;
         end
      end
   end

   // TDO mux: bit 0 of the active shift path, zero elsewhere
   always_comb begin
      tdo = 1'b0;
      if (state == S_SH_IR) begin
         tdo = r_ir_sr[0];
      end else if (w_sh_dr) begin
         if (w_sel_id) begin
            tdo = r_id_sr[0];
         end else if (w_sel_user) begin
            tdo = r_user_sr[0];
         end else begin
            tdo = r_bp;
         end
      end
   end

   assign tdo_en   = (state == S_SH_DR) || (state == S_SH_IR);
   assign ir_out   = r_ir;
   assign user_out = r_user_out;
   assign user_upd = r_user_upd;

endmodule

// File: tb/tb_jtag_ir_dr_datapath.sv
// Bench for jtag_ir_dr_datapath: directed TAP walks, a
// register-level reference model and a per-cycle compare.
module tb_jtag_ir_dr_datapath;

   logic       tck;
   logic       trst;
   logic [3:0] state;
   logic       tdi;
   logic [7:0] user_in;
   logic       tdo;
   logic       tdo_en;
   logic [3:0] ir_out;
   logic [7:0] user_out;
   logic       user_upd;

   int n_vec = 0;
   int n_err = 0;

   jtag_ir_dr_datapath dut (
      .tck      (tck),
      .trst     (trst),
      .state    (state),
      .tdi      (tdi),
      .user_in  (user_in),
      .tdo      (tdo),
      .tdo_en   (tdo_en),
      .ir_out   (ir_out),
      .user_out (user_out),
      .user_upd (user_upd)
   );

   initial tck = 1'b0;
   always #5 tck = ~tck;

   // ---------------- reference model ----------------
   logic [3:0]  m_ir_sr, m_ir;
   logic [31:0] m_id;
   logic [7:0]  m_user, m_uout;
   logic        m_bp, m_upd;

   function automatic int dr_sel(input logic [3:0] ir);
      if (ir == 4'd1) return 1;
      if (ir == 4'd2) return 2;
      return 0;
   endfunction

   always @(posedge tck or posedge trst) begin
      if (trst) begin
         m_ir_sr <= 4'd1; m_ir <= 4'd1; m_id <= 32'h1234_5001;
         m_user <= 8'd0; m_bp <= 1'b0; m_uout <= 8'd0; m_upd <= 1'b0;
      end else begin
         m_upd <= 1'b0;
         if (state == 4'd0) m_ir <= 4'd1;
         if (state == 4'd10) m_ir_sr <= 4'd1;
         if (state == 4'd11) m_ir_sr <= (m_ir_sr >> 1) | (4'(tdi) << 3);
         if (state == 4'd15) m_ir <= m_ir_sr;
         if (state == 4'd3) begin
            case (dr_sel(m_ir))
               1: m_id <= 32'h1234_5001;
               2: m_user <= user_in;
               default: m_bp <= 1'b0;
            endcase
         end
         if (state == 4'd4) begin
            case (dr_sel(m_ir))
               1: m_id <= (m_id >> 1) | (32'(tdi) << 31);
               2: m_user <= (m_user >> 1) | (8'(tdi) << 7);
               default: m_bp <= tdi;
            endcase
         end
         if (state == 4'd8 && dr_sel(m_ir) == 2) begin
            m_uout <= m_user;
            m_upd <= 1'b1;
         end
      end
   end

   function automatic logic exp_tdo();
      if (state == 4'd11) return m_ir_sr[0];
      if (state == 4'd4) begin
         case (dr_sel(m_ir))
            1: return m_id[0];
            2: return m_user[0];
            default: return m_bp;
         endcase
      end
      return 1'b0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // per-cycle compare against the model
   always @(negedge tck) begin
      chk("tdo", 32'(tdo), 32'(exp_tdo()));
      chk("tdo_en", 32'(tdo_en), 32'(state == 4'd4 || state == 4'd11));
      chk("ir_out", 32'(ir_out), 32'(m_ir));
      chk("user_out", 32'(user_out), 32'(m_uout));
      chk("user_upd", 32'(user_upd), 32'(m_upd));
   end

   // ---------------- stimulus helpers ----------------
   logic last_tdo;

   task automatic cyc(input logic [3:0] st, input logic d);
      state = st;
      tdi   = d;
      @(negedge tck);
      last_tdo = tdo;
      @(posedge tck);
      #1;
   endtask

   // from RTI: load IR, returns captured IR bits (LSB first)
   task automatic load_ir(input logic [3:0] v, output logic [3:0] got);
      cyc(4'd2, 1'b0);
      cyc(4'd9, 1'b0);
      cyc(4'd10, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc(4'd11, v[i]);
         got[i] = last_tdo;
      end
      cyc(4'd12, 1'b0);
      cyc(4'd15, 1'b0);
      cyc(4'd1, 1'b0);
   endtask

   // from RTI: capture, shift n bits, update, back to RTI
   task automatic shift_dr(input int n, input logic [31:0] din,
                           output logic [31:0] dout);
      dout = '0;
      cyc(4'd2, 1'b0);
      cyc(4'd3, 1'b0);
      for (int i = 0; i < n; i++) begin
         cyc(4'd4, din[i]);
         dout[i] = last_tdo;
      end
      cyc(4'd5, 1'b0);
      cyc(4'd8, 1'b0);
      cyc(4'd1, 1'b0);
   endtask

   logic [3:0]  irb;
   logic [31:0] dout;

   initial begin
      trst = 1'b0; state = 4'd0; tdi = 1'b0; user_in = 8'h00;
      #1 trst = 1'b1;
      cyc(4'd0, 1'b0);
      cyc(4'd0, 1'b0);
      chk("rst ir_out", 32'(ir_out), 32'h1);
      chk("rst tdo_en", 32'(tdo_en), 32'h0);
      chk("rst tdo", 32'(tdo), 32'h0);
      chk("rst user_out", 32'(user_out), 32'h0);
      trst = 1'b0;
      cyc(4'd0, 1'b0);
      cyc(4'd1, 1'b0);

      // IDCODE read
      shift_dr(32, 32'h0, dout);
      chk("idcode stream", dout, 32'h1234_5001);

      // IR load USER
      load_ir(4'h2, irb);
      chk("ir cap bits", 32'(irb[1:0]), 32'h1);
      chk("ir_out user", 32'(ir_out), 32'h2);

      // USER capture/shift/update
      user_in = 8'hA5;
      cyc(4'd2, 1'b0);
      cyc(4'd3, 1'b0);
      dout = '0;
      for (int i = 0; i < 8; i++) begin
         cyc(4'd4, 8'h3C >> i);
         dout[i] = last_tdo;
      end
      cyc(4'd5, 1'b0);
      cyc(4'd8, 1'b0);
      chk("user upd pulse", 32'(user_upd), 32'h1);
      chk("user_out", 32'(user_out), 32'h3C);
      cyc(4'd1, 1'b0);
      chk("user upd low", 32'(user_upd), 32'h0);
      chk("user stream", dout, 32'hA5);

      // BYPASS and illegal code
      load_ir(4'hF, irb);
      chk("ir_out F", 32'(ir_out), 32'hF);
      shift_dr(4, 32'hD, dout);
      chk("bypass F", dout, 32'hA);
      load_ir(4'h7, irb);
      chk("ir_out 7", 32'(ir_out), 32'h7);
      shift_dr(4, 32'hD, dout);
      chk("bypass 7", dout, 32'hA);

      // Pause/resume on USER
      load_ir(4'h2, irb);
      user_in = 8'h5A;
      cyc(4'd2, 1'b0);
      cyc(4'd3, 1'b0);
      dout = '0;
      for (int i = 0; i < 4; i++) begin
         cyc(4'd4, 8'h96 >> i);
         dout[i] = last_tdo;
      end
      cyc(4'd5, 1'b0);
      for (int i = 0; i < 3; i++) cyc(4'd6, 1'b1);
      cyc(4'd7, 1'b0);
      for (int i = 4; i < 8; i++) begin
         cyc(4'd4, 8'h96 >> i);
         dout[i] = last_tdo;
      end
      cyc(4'd5, 1'b0);
      cyc(4'd8, 1'b0);
      chk("pause user_out", 32'(user_out), 32'h96);
      chk("pause stream", dout, 32'h5A);
      cyc(4'd1, 1'b0);

      // Async reset mid-shift
      user_in = 8'hFF;
      cyc(4'd2, 1'b0);
      cyc(4'd3, 1'b0);
      cyc(4'd4, 1'b1);
      cyc(4'd4, 1'b0);
      trst = 1'b1;
      #2;
      chk("async ir_out", 32'(ir_out), 32'h1);
      chk("async user_sr", 32'(dut.r_user_sr), 32'h0);
      #3 trst = 1'b0;
      @(posedge tck);
      #1;
      cyc(4'd5, 1'b0);
      cyc(4'd8, 1'b0);
      cyc(4'd1, 1'b0);
      shift_dr(32, 32'h0, dout);
      chk("post rst idcode", dout, 32'h1234_5001);

      // TLR forces IDCODE
      load_ir(4'h2, irb);
      chk("ir_out 2 again", 32'(ir_out), 32'h2);
      cyc(4'd0, 1'b0);
      chk("tlr ir_out", 32'(ir_out), 32'h1);
      cyc(4'd1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
